// File: rtl/logic_acc_win.sv
// Multi-channel windowed reduction accumulator: folds PAR_WIN_LEN accepted samples per lane
// with a per-window latched XOR/OR/AND/ADD operator and strobes out each completed result.
module logic_acc_win #(
    parameter int PAR_DATA_BITS = 8,
    parameter int PAR_CHANNELS  = 4,
    parameter int PAR_WIN_LEN   = 16,
    localparam int CNT_W        = (PAR_WIN_LEN > 1) ? $clog2(PAR_WIN_LEN) : 1
) (
    input  logic                                  ib_clk,
    input  logic                                  ib_rst,
    input  logic [1:0]                            ivG_mode,
    input  logic                                  ib_clear,
    input  logic                                  ib_valid,
    input  logic [PAR_CHANNELS*PAR_DATA_BITS-1:0] ivG_data,
    output logic                                  ob_valid,
    output logic [PAR_CHANNELS*PAR_DATA_BITS-1:0] ovG_data,
    output logic [CNT_W-1:0]                      ovG_count
);

    localparam int              W        = PAR_DATA_BITS;
    localparam int              BUS_W    = PAR_CHANNELS * PAR_DATA_BITS;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PAR_WIN_LEN - 1);

    typedef enum logic [1:0] {
        MODE_XOR = 2'b00,
        MODE_OR  = 2'b01,
        MODE_AND = 2'b10,
        MODE_ADD = 2'b11
    } mode_e;

    typedef enum logic {
        ST_IDLE,
        ST_ACC
    } state_e;

    state_e           state_q, state_d;
    mode_e            mode_q,  mode_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [BUS_W-1:0] acc_q,   acc_d;
    logic [BUS_W-1:0] res_q,   res_d;
    logic             valid_q, valid_d;
    logic [BUS_W-1:0] acc_op;

    function automatic logic [W-1:0] lane_op(input mode_e mode, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        case (mode)
            MODE_XOR: return a ^ b;
            MODE_OR:  return a | b;
            MODE_AND: return a & b;
            default:  return a + b;  // ADD wraps inside the lane
        endcase
    endfunction

    always_comb begin
        acc_op = '0;
        for (int c = 0; c < PAR_CHANNELS; c++) begin
            acc_op[c*W +: W] = lane_op(mode_q, acc_q[c*W +: W], ivG_data[c*W +: W]);
        end
    end

    // NOTE: every _d takes its _q value first, so no path through this block can infer a latch.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        count_d = count_q;
        acc_d   = acc_q;
        res_d   = res_q;
        valid_d = 1'b0;

        if (ib_clear) begin
            state_d = ST_IDLE;
            count_d = '0;
        end else if (ib_valid) begin
            if (state_q == ST_IDLE) begin
                // The first sample of a window is the seed; no identity value is required.
                acc_d  = ivG_data;
                mode_d = mode_e'(ivG_mode);
                if (PAR_WIN_LEN == 1) begin
                    res_d   = ivG_data;
                    valid_d = 1'b1;
                end else begin
                    state_d = ST_ACC;
                    count_d = CNT_W'(1);
                end
            end else if (count_q == LAST_CNT) begin
                res_d   = acc_op;
                valid_d = 1'b1;
                state_d = ST_IDLE;
                count_d = '0;
            end else begin
                acc_d   = acc_op;
                count_d = count_q + CNT_W'(1);
            end
        end
    end

    // NOTE: non-blocking assignments throughout, so every flop samples pre-edge values.
    // NOTE: accumulators are reset too, so a mid-window reset can never leak a stale partial.
    always_ff @(posedge ib_clk) begin
        if (ib_rst) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_XOR;
            count_q <= '0;
            acc_q   <= '0;
            res_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            count_q <= count_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
            valid_q <= valid_d;
        end
    end

    assign ob_valid  = valid_q;
    assign ovG_data  = res_q;
    assign ovG_count = count_q;

endmodule

// File: tb/tb_logic_acc_win.sv
// Bench for logic_acc_win: a 2-lane, 4-sample instance against a queue-based window model,
// plus a 1-sample-window instance for the degenerate window length.
module tb_logic_acc_win;

    logic        clk;
    logic        ib_rst;
    logic [1:0]  ivG_mode;
    logic        ib_clear;
    logic        ib_valid;
    logic [15:0] ivG_data;
    logic        ob_valid;
    logic [15:0] ovG_data;
    logic [1:0]  ovG_count;

    logic [1:0]  w_mode;
    logic        w_clear;
    logic        w_valid;
    logic [15:0] w_data;
    logic        w_ob_valid;
    logic [15:0] w_ovg_data;
    logic [0:0]  w_count;

    int errors = 0;
    int checks = 0;

    // Reference model: the open window is a list of accepted samples, reduced when full.
    logic [15:0] win_q[$];
    logic [1:0]  win_mode;
    logic        m_valid;
    logic [15:0] m_data;
    int          m_count;

    logic_acc_win #(.PAR_DATA_BITS(8), .PAR_CHANNELS(2), .PAR_WIN_LEN(4)) u_dut (
        .ib_clk(clk), .ib_rst(ib_rst), .ivG_mode(ivG_mode), .ib_clear(ib_clear),
        .ib_valid(ib_valid), .ivG_data(ivG_data), .ob_valid(ob_valid),
        .ovG_data(ovG_data), .ovG_count(ovG_count)
    );

    logic_acc_win #(.PAR_DATA_BITS(8), .PAR_CHANNELS(2), .PAR_WIN_LEN(1)) u_dut_w1 (
        .ib_clk(clk), .ib_rst(ib_rst), .ivG_mode(w_mode), .ib_clear(w_clear),
        .ib_valid(w_valid), .ivG_data(w_data), .ob_valid(w_ob_valid),
        .ovG_data(w_ovg_data), .ovG_count(w_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] reduce_window(input logic [1:0] md);
        logic [15:0] r;
        for (int c = 0; c < 2; c++) begin
            int acc;
            acc = int'(win_q[0][c*8 +: 8]);
            for (int k = 1; k < win_q.size(); k++) begin
                int x;
                x = int'(win_q[k][c*8 +: 8]);
                case (md)
                    2'b00: acc = acc ^ x;
                    2'b01: acc = acc | x;
                    2'b10: acc = acc & x;
                    default: acc = (acc + x) % 256;
                endcase
            end
            r[c*8 +: 8] = 8'(acc);
        end
        return r;
    endfunction

    task automatic model_step(input logic rst, input logic clr, input logic vld,
                              input logic [1:0] md, input logic [15:0] dat);
        m_valid = 1'b0;
        if (rst) begin
            win_q.delete();
            m_data = '0;
        end else if (clr) begin
            win_q.delete();
        end else if (vld) begin
            if (win_q.size() == 0) win_mode = md;
            win_q.push_back(dat);
            if (win_q.size() == 4) begin
                m_data  = reduce_window(win_mode);
                m_valid = 1'b1;
                win_q.delete();
            end
        end
        m_count = win_q.size();
    endtask

    task automatic drive(input logic rst, input logic clr, input logic vld,
                         input logic [1:0] md, input logic [15:0] dat);
        @(negedge clk);
        ib_rst   = rst;
        ib_clear = clr;
        ib_valid = vld;
        ivG_mode = md;
        ivG_data = dat;
        model_step(rst, clr, vld, md, dat);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            w_valid = 1'b1;
            w_mode  = 2'($urandom);
            w_data  = 16'($urandom);
            drive(1'b1, 1'($urandom), 1'b1, 2'($urandom), 16'($urandom));
            if (ob_valid !== 1'b0 || ovG_data !== 16'h0000 || ovG_count !== 2'd0) begin
                errors++;
                $display("FAIL reset[%0d]: got v=%b d=%h c=%0d want v=0 d=0000 c=0",
                         i, ob_valid, ovG_data, ovG_count);
            end
            checks++;
            if (w_ob_valid !== 1'b0 || w_ovg_data !== 16'h0000 || w_count !== 1'b0) begin
                errors++;
                $display("FAIL reset_w1[%0d]: got v=%b d=%h c=%0d want v=0 d=0000 c=0",
                         i, w_ob_valid, w_ovg_data, w_count);
            end
            checks++;
        end
        w_valid = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 2'b00, 16'h0000);
    endtask

    task automatic test_xor_basic();
        logic [15:0] stim [4];
        logic [1:0]  want_cnt [4];
        stim     = '{16'hFF01, 16'hFF02, 16'h0004, 16'h0108};
        want_cnt = '{2'd1, 2'd2, 2'd3, 2'd0};
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 1'b1, 2'b00, stim[i]);
            if (ob_valid !== m_valid || ovG_data !== m_data || ovG_count !== want_cnt[i]) begin
                errors++;
                $display("FAIL xor_basic[%0d]: got v=%b d=%h c=%0d want v=%b d=%h c=%0d",
                         i, ob_valid, ovG_data, ovG_count, m_valid, m_data, want_cnt[i]);
            end
            checks++;
        end
        if (ob_valid !== 1'b1 || ovG_data !== 16'h010F) begin
            errors++;
            $display("FAIL xor_result: got v=%b d=%h want v=1 d=010f", ob_valid, ovG_data);
        end
        checks++;
        drive(1'b0, 1'b0, 1'b0, 2'b11, 16'($urandom));
        if (ob_valid !== 1'b0 || ovG_data !== 16'h010F || ovG_count !== 2'd0) begin
            errors++;
            $display("FAIL xor_hold: got v=%b d=%h c=%0d want v=0 d=010f c=0",
                     ob_valid, ovG_data, ovG_count);
        end
        checks++;
    endtask

    task automatic test_add_gaps();
        logic [7:0] lane0 [4];
        int         gaps [4];
        int         strobes;
        lane0   = '{8'hFF, 8'h01, 8'h10, 8'h20};
        gaps    = '{0, 3, 1, 2};
        strobes = 0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 1'b1, 2'b11, {8'($urandom), lane0[i]});
            if (ob_valid === 1'b1) strobes++;
            if (ob_valid !== m_valid || ovG_data !== m_data || ovG_count !== 2'(m_count)) begin
                errors++;
                $display("FAIL add_gaps[%0d]: got v=%b d=%h c=%0d want v=%b d=%h c=%0d",
                         i, ob_valid, ovG_data, ovG_count, m_valid, m_data, m_count);
            end
            checks++;
            if (i == 3 && (ob_valid !== 1'b1 || ovG_data[7:0] !== 8'h30)) begin
                errors++;
                $display("FAIL add_wrap: got v=%b lane0=%h want v=1 lane0=30",
                         ob_valid, ovG_data[7:0]);
            end
            if (i == 3) checks++;
            for (int g = 0; g < gaps[i]; g++) begin
                drive(1'b0, 1'b0, 1'b0, 2'($urandom), 16'($urandom));
                if (ob_valid === 1'b1) strobes++;
                if (ob_valid !== m_valid || ovG_count !== 2'(m_count)) begin
                    errors++;
                    $display("FAIL add_gap_hold[%0d.%0d]: got v=%b c=%0d want v=%b c=%0d",
                             i, g, ob_valid, ovG_count, m_valid, m_count);
                end
                checks++;
            end
        end
        if (strobes !== 1) begin
            errors++;
            $display("FAIL add_strobes: got %0d want 1", strobes);
        end
        checks++;
    endtask

    task automatic test_mode_latch();
        logic [7:0] l_and [4];
        logic [7:0] l_or [4];
        l_and = '{8'hFF, 8'hF0, 8'h3C, 8'hFF};
        l_or  = '{8'h01, 8'h02, 8'h00, 8'h00};
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 1'b1, (i == 0) ? 2'b10 : 2'b01, {8'($urandom), l_and[i]});
            if (ob_valid !== m_valid || ovG_data !== m_data || ovG_count !== 2'(m_count)) begin
                errors++;
                $display("FAIL mode_latch_and[%0d]: got v=%b d=%h c=%0d want v=%b d=%h c=%0d",
                         i, ob_valid, ovG_data, ovG_count, m_valid, m_data, m_count);
            end
            checks++;
        end
        if (ovG_data[7:0] !== 8'h30) begin
            errors++;
            $display("FAIL mode_latch_and_lane0: got %h want 30", ovG_data[7:0]);
        end
        checks++;
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 1'b1, (i == 0) ? 2'b01 : 2'($urandom), {8'($urandom), l_or[i]});
            if (ob_valid !== m_valid || ovG_data !== m_data || ovG_count !== 2'(m_count)) begin
                errors++;
                $display("FAIL mode_latch_or[%0d]: got v=%b d=%h c=%0d want v=%b d=%h c=%0d",
                         i, ob_valid, ovG_data, ovG_count, m_valid, m_data, m_count);
            end
            checks++;
        end
        if (ob_valid !== 1'b1 || ovG_data[7:0] !== 8'h03) begin
            errors++;
            $display("FAIL mode_latch_or_lane0: got v=%b lane0=%h want v=1 lane0=03",
                     ob_valid, ovG_data[7:0]);
        end
        checks++;
    endtask

    task automatic test_clear();
        logic [7:0] first [4];
        logic [7:0] after [4];
        first = '{8'h01, 8'h02, 8'h04, 8'h08};
        after = '{8'h11, 8'h22, 8'h44, 8'h88};
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 1'b1, 2'b00, {8'h00, first[i]});
        if (ob_valid !== 1'b1 || ovG_data !== 16'h000F) begin
            errors++;
            $display("FAIL clear_setup: got v=%b d=%h want v=1 d=000f", ob_valid, ovG_data);
        end
        checks++;
        drive(1'b0, 1'b0, 1'b1, 2'($urandom), 16'($urandom));
        drive(1'b0, 1'b0, 1'b1, 2'($urandom), 16'($urandom));
        drive(1'b0, 1'b1, 1'b1, 2'($urandom), 16'($urandom));
        if (ob_valid !== 1'b0 || ovG_data !== 16'h000F || ovG_count !== 2'd0) begin
            errors++;
            $display("FAIL clear_abort: got v=%b d=%h c=%0d want v=0 d=000f c=0",
                     ob_valid, ovG_data, ovG_count);
        end
        checks++;
        drive(1'b0, 1'b1, 1'b0, 2'($urandom), 16'($urandom));
        if (ob_valid !== 1'b0 || ovG_data !== 16'h000F || ovG_count !== 2'd0) begin
            errors++;
            $display("FAIL clear_idle: got v=%b d=%h c=%0d want v=0 d=000f c=0",
                     ob_valid, ovG_data, ovG_count);
        end
        checks++;
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 1'b1, 2'b00, {8'($urandom), after[i]});
            if (ob_valid !== m_valid || ovG_data !== m_data || ovG_count !== 2'(m_count)) begin
                errors++;
                $display("FAIL clear_next[%0d]: got v=%b d=%h c=%0d want v=%b d=%h c=%0d",
                         i, ob_valid, ovG_data, ovG_count, m_valid, m_data, m_count);
            end
            checks++;
        end
        if (ovG_data[7:0] !== 8'hFF) begin
            errors++;
            $display("FAIL clear_next_lane0: got %h want ff", ovG_data[7:0]);
        end
        checks++;
    endtask

    task automatic test_back_to_back();
        int strobe_at [$];
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b0, 1'b1, 2'($urandom), 16'($urandom));
            if (ob_valid === 1'b1) strobe_at.push_back(i);
            if (ob_valid !== m_valid || ovG_data !== m_data || ovG_count !== 2'(m_count)) begin
                errors++;
                $display("FAIL b2b[%0d]: got v=%b d=%h c=%0d want v=%b d=%h c=%0d",
                         i, ob_valid, ovG_data, ovG_count, m_valid, m_data, m_count);
            end
            checks++;
        end
        if (strobe_at.size() != 2 || strobe_at[0] != 3 || strobe_at[1] != 7) begin
            errors++;
            $display("FAIL b2b_strobes: got %0d strobes (first at %0d) want 2 at 3 and 7",
                     strobe_at.size(), (strobe_at.size() > 0) ? strobe_at[0] : -1);
        end
        checks++;
        drive(1'b0, 1'b0, 1'b1, 2'($urandom), 16'($urandom));
        drive(1'b0, 1'b0, 1'b1, 2'($urandom), 16'($urandom));
        drive(1'b1, 1'b0, 1'b1, 2'($urandom), 16'($urandom));
        if (ob_valid !== 1'b0 || ovG_data !== 16'h0000 || ovG_count !== 2'd0) begin
            errors++;
            $display("FAIL b2b_reset: got v=%b d=%h c=%0d want v=0 d=0000 c=0",
                     ob_valid, ovG_data, ovG_count);
        end
        checks++;
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 1'b1, 2'($urandom), 16'($urandom));
            if (ob_valid !== m_valid || ovG_data !== m_data || ovG_count !== 2'(m_count)) begin
                errors++;
                $display("FAIL b2b_fresh[%0d]: got v=%b d=%h c=%0d want v=%b d=%h c=%0d",
                         i, ob_valid, ovG_data, ovG_count, m_valid, m_data, m_count);
            end
            checks++;
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(0, 59) == 0), ($urandom_range(0, 11) == 0),
                  ($urandom_range(0, 2) != 0), 2'($urandom), 16'($urandom));
            if (ob_valid !== m_valid || ovG_data !== m_data || ovG_count !== 2'(m_count)) begin
                errors++;
                $display("FAIL random[%0d]: got v=%b d=%h c=%0d want v=%b d=%h c=%0d",
                         i, ob_valid, ovG_data, ovG_count, m_valid, m_data, m_count);
            end
            checks++;
        end
    endtask

    task automatic test_win1();
        logic [15:0] samp [2];
        samp = '{16'h125A, 16'h34A5};
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            w_clear = 1'b0;
            w_valid = 1'b1;
            w_mode  = 2'b01;
            w_data  = samp[i];
            @(posedge clk);
            #1;
            if (w_ob_valid !== 1'b1 || w_ovg_data !== samp[i] || w_count !== 1'b0) begin
                errors++;
                $display("FAIL win1[%0d]: got v=%b d=%h c=%0d want v=1 d=%h c=0",
                         i, w_ob_valid, w_ovg_data, w_count, samp[i]);
            end
            checks++;
        end
        @(negedge clk);
        w_clear = 1'b1;
        w_data  = 16'hBEEF;
        @(posedge clk);
        #1;
        if (w_ob_valid !== 1'b0 || w_ovg_data !== 16'h34A5) begin
            errors++;
            $display("FAIL win1_clear: got v=%b d=%h want v=0 d=34a5", w_ob_valid, w_ovg_data);
        end
        checks++;
        @(negedge clk);
        w_clear = 1'b0;
        w_valid = 1'b0;
        @(posedge clk);
        #1;
        if (w_ob_valid !== 1'b0 || w_ovg_data !== 16'h34A5) begin
            errors++;
            $display("FAIL win1_hold: got v=%b d=%h want v=0 d=34a5", w_ob_valid, w_ovg_data);
        end
        checks++;
    endtask

    initial begin
        ib_rst   = 1'b1;
        ib_clear = 1'b0;
        ib_valid = 1'b0;
        ivG_mode = 2'b00;
        ivG_data = '0;
        w_mode   = 2'b00;
        w_clear  = 1'b0;
        w_valid  = 1'b0;
        w_data   = '0;
        win_mode = 2'b00;
        m_valid  = 1'b0;
        m_data   = '0;
        m_count  = 0;

        test_reset();
        test_xor_basic();
        test_add_gaps();
        test_mode_latch();
        test_clear();
        test_back_to_back();
        test_random();
        test_win1();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
